// File: rtl/pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// pipe_stage_chain
//   Parametrised chain of pipeline registers. Each register carries a WIDTH-bit
//   payload and a valid bit. The hazard unit only raises raw per-stage stall
//   and flush requests. This block does the rest: it propagates each stall
//   backwards to every earlier stage, inserts a bubble at each stall boundary,
//   and counts stall cycles and inserted bubbles.
//
//   Per-stage priority on each rising edge: flush > hold > bubble > advance.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    payload entering stage 0
//   in_valid   in_data is a real instruction
//   in_ready   stage 0 accepts in_data this cycle (PC enable), combinational
//   stall      raw stall request per stage (bit i = stage i)
//   flush      raw flush request per stage
//   out_data   stage i payload at [i*WIDTH +: WIDTH]
//   out_valid  stage i valid bit
//   stall_cnt  saturating count of cycles with in_ready == 0
//   bubble_cnt saturating count of bubbles inserted at stall boundaries
// ----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int unsigned       WIDTH  = 32,
    parameter int unsigned       STAGES = 4,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter int unsigned       CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   out_data,
    output logic [STAGES-1:0]         out_valid,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    // stall_eff[i] is set when stage i or any later stage stalls.
    logic [STAGES-1:0] stall_eff;
    // bub[i]: stage i is free to move but its upstream neighbour is frozen,
    // so it must take a bubble instead of duplicating that neighbour.
    logic [STAGES-1:0] bub;

    for (genvar i = 0; i < STAGES; i++) begin : g_eff
        assign stall_eff[i] = |stall[STAGES-1:i];
    end

    assign bub[0] = 1'b0;
    for (genvar i = 1; i < STAGES; i++) begin : g_bub
        assign bub[i] = ~flush[i] & ~stall_eff[i] & stall_eff[i-1];
    end

    assign in_ready = ~stall_eff[0];

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        if (i == 0) begin : g_src_in
            assign src_data  = in_data;
            assign src_valid = in_valid;
        end else begin : g_src_prev
            assign src_data  = out_data[(i-1)*WIDTH +: WIDTH];
            assign src_valid = out_valid[i-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= BUBBLE;
                valid_q <= 1'b0;
            end else if (flush[i] || bub[i]) begin
                data_q  <= BUBBLE;
                valid_q <= 1'b0;
            end else if (!stall_eff[i]) begin
                data_q  <= src_data;
                valid_q <= src_valid;
            end
        end

        assign out_data[i*WIDTH +: WIDTH] = data_q;
        assign out_valid[i]               = valid_q;
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    // The extra top bit of bub_sum catches overflow when several boundaries
    // land in one cycle.
    logic [CNT_W:0] bub_sum;
    assign bub_sum = {1'b0, bubble_cnt} + (CNT_W+1)'($countones(bub));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            bubble_cnt <= bub_sum[CNT_W] ? '1 : bub_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Self-checking bench for pipe_stage_chain (WIDTH=16, STAGES=4, CNT_W=4,
//   non-zero BUBBLE so bubbles are distinguishable from zero payloads).
//   Inputs are driven on the falling edge. A scoreboard queues each accepted
//   payload and compares it when the last stage loads a valid payload.
// ----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int unsigned      W   = 16;
    localparam int unsigned      S   = 4;
    localparam int unsigned      CW  = 4;
    localparam logic [W-1:0]     BUB = 16'h0013;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [S-1:0]     stall = '0;
    logic [S-1:0]     flush = '0;
    logic [S*W-1:0]   out_data;
    logic [S-1:0]     out_valid;
    logic [CW-1:0]    stall_cnt;
    logic [CW-1:0]    bubble_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [W-1:0] exp_q[$];
    bit           sb_en = 1'b0;

    pipe_stage_chain #(
        .WIDTH (W),
        .STAGES(S),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] stg(input int i);
        return out_data[i*W +: W];
    endfunction

    // Scoreboard: push on acceptance into stage 0, pop when stage 3 loads
    // a valid payload. Only used in phases without flushes.
    always @(posedge clk) begin
        bit ld;
        ld = sb_en && !rst && !flush[3] && !stall[3];
        if (sb_en && !rst && in_valid && stall == '0 && !flush[0])
            exp_q.push_back(in_data);
        #1;
        if (ld && out_valid[3]) begin
            chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("sb_out", 64'(stg(3)), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = '0; flush = '0; in_valid = 1'b0; in_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] v);
        in_data = v; in_valid = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), {4{BUB}});
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // 1: free flow, 1..5 reach stage 3 on cycles 4..8
        sb_en = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            in_valid = (cyc <= 5);
            in_data  = (cyc <= 5) ? W'(cyc) : '0;
            tick();
            if (cyc >= 4 && cyc <= 8) begin
                chk("ff_stage3", 64'(stg(3)), 64'(cyc - 3));
                chk("ff_valid3", 64'(out_valid[3]), 64'h1);
            end
        end
        chk("ff_stall_cnt", 64'(stall_cnt), 64'h0);
        chk("ff_bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("ff_drained", 64'(exp_q.size()), 64'h0);

        // 2: load-use stall on stage 1
        do_reset();
        feed(16'h0008); feed(16'h0009); feed(16'h000A); feed(16'h000B);
        stall = 4'b0010; in_data = 16'h000C; in_valid = 1'b1;
        #1 chk("lu_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("lu_s0", 64'(stg(0)), 64'h000B);
        chk("lu_s1", 64'(stg(1)), 64'h000A);
        chk("lu_s2", 64'(stg(2)), 64'(BUB));
        chk("lu_v2", 64'(out_valid[2]), 64'h0);
        chk("lu_s3", 64'(stg(3)), 64'h0009);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'h1);
        chk("lu_bubble_cnt", 64'(bubble_cnt), 64'h1);
        stall = '0;
        #1 chk("lu_in_ready_rel", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("lu_drained", 64'(exp_q.size()), 64'h0);
        chk("lu_stall_cnt_end", 64'(stall_cnt), 64'h1);
        sb_en = 1'b0;

        // 3: branch flush of stages 0 and 1
        do_reset();
        feed(16'h0008); feed(16'h000C); feed(16'h0010); feed(16'h0014);
        in_valid = 1'b0; flush = 4'b0011;
        tick();
        flush = '0;
        chk("br_s0", 64'(stg(0)), 64'(BUB));
        chk("br_v0", 64'(out_valid[0]), 64'h0);
        chk("br_s1", 64'(stg(1)), 64'(BUB));
        chk("br_v1", 64'(out_valid[1]), 64'h0);
        chk("br_s2", 64'(stg(2)), 64'h0010);
        chk("br_v2", 64'(out_valid[2]), 64'h1);
        chk("br_s3", 64'(stg(3)), 64'h000C);
        chk("br_bubble_cnt", 64'(bubble_cnt), 64'h0);

        // 4: stall[2] together with flush[1]
        do_reset();
        feed(16'h0001); feed(16'h0002); feed(16'h0003); feed(16'h0004);
        stall = 4'b0100; flush = 4'b0010; in_data = 16'h0005;
        tick();
        stall = '0; flush = '0; in_valid = 1'b0;
        chk("fs_s0", 64'(stg(0)), 64'h0004);
        chk("fs_v0", 64'(out_valid[0]), 64'h1);
        chk("fs_s1", 64'(stg(1)), 64'(BUB));
        chk("fs_v1", 64'(out_valid[1]), 64'h0);
        chk("fs_s2", 64'(stg(2)), 64'h0002);
        chk("fs_s3", 64'(stg(3)), 64'(BUB));
        chk("fs_v3", 64'(out_valid[3]), 64'h0);
        chk("fs_bubble_cnt", 64'(bubble_cnt), 64'h1);
        chk("fs_stall_cnt", 64'(stall_cnt), 64'h1);

        // 5: async reset in the middle of a stall
        do_reset();
        feed(16'h0001); feed(16'h0002); feed(16'h0003); feed(16'h0004);
        in_valid = 1'b0; stall = 4'b1000;
        tick(); tick();
        chk("ar_pre_stall_cnt", 64'(stall_cnt), 64'h2);
        chk("ar_pre_s3", 64'(stg(3)), 64'h0001);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_data", 64'(out_data), {4{BUB}});
        chk("ar_stall_cnt", 64'(stall_cnt), 64'h0);
        tick();
        stall = '0; rst = 1'b0;
        #1 chk("ar_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("ar_cnts", 64'({stall_cnt, bubble_cnt}), 64'h0);

        // 6: saturation with a 4-bit counter
        do_reset();
        stall = 4'b0001;
        repeat (14) tick();
        chk("sat_stall_14", 64'(stall_cnt), 64'd14);
        chk("sat_bubble_14", 64'(bubble_cnt), 64'd14);
        repeat (6) tick();
        chk("sat_stall_20", 64'(stall_cnt), 64'd15);
        chk("sat_bubble_20", 64'(bubble_cnt), 64'd15);
        stall = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
